// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
package fir_pkg;

  localparam int SAMPLE_W_DEF = 8;
  localparam int OUT_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_e;

  // Reports whether v falls outside the signed range of a w-bit result.
  function automatic sat_e saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return SAT_HI;
    end else if (v < lo) begin
      return SAT_LO;
    end
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiply-accumulate with a saturating, registered output stage.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int ACC_W    = 2 * SAMPLE_W_DEF + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic                       load_i,
  input  logic signed [SAMPLE_W-1:0] coef_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic signed [OUT_W-1:0]    y_o,
  output logic                       y_sat_o
);

  localparam int PROD_W = 2 * SAMPLE_W;
  localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic signed [63:0]       acc_ext;
  logic signed [OUT_W-1:0]  y_q, y_d;
  logic                     y_sat_q, y_sat_d;
  sat_e                     sat_code;

  assign prod     = coef_i * sample_i;
  assign acc_sum  = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_ext  = {{(64 - ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
  assign sat_code = saturate(acc_ext, OUT_W);

  // The output is taken from the sum including the final tap's product.
  always_comb begin
    acc_d   = acc_q;
    y_d     = y_q;
    y_sat_d = y_sat_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_sum;
    end
    if (load_i) begin
      case (sat_code)
        SAT_HI: begin
          y_d     = Y_MAX;
          y_sat_d = 1'b1;
        end
        SAT_LO: begin
          y_d     = Y_MIN;
          y_sat_d = 1'b1;
        end
        default: begin
          y_d     = acc_sum[OUT_W-1:0];
          y_sat_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      y_q     <= '0;
      y_sat_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      y_q     <= y_d;
      y_sat_q <= y_sat_d;
    end
  end

  assign y_o     = y_q;
  assign y_sat_o = y_sat_q;

endmodule

// File: rtl/fir_tdm_sequencer.sv
// FIR controller sharing one MAC across all taps: delay line, coefficient
// bank, tap sequencing FSM and valid/ready handshakes.
module fir_tdm_sequencer
  import fir_pkg::*;
#(
  parameter int N        = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] x_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       coef_we,
  input  logic [$clog2(N)-1:0]       coef_addr,
  input  logic signed [SAMPLE_W-1:0] coef_wdata,
  output logic                       coef_ready,
  output logic signed [OUT_W-1:0]    y_out,
  output logic                       y_sat,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int ADDR_W = $clog2(N);
  localparam int ACC_W  = 2 * SAMPLE_W + $clog2(N);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N - 1);

  fir_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   tap_q, tap_d;
  logic signed [SAMPLE_W-1:0] shift_q [N];
  logic signed [SAMPLE_W-1:0] shift_d [N];
  logic signed [SAMPLE_W-1:0] coef_q  [N];
  logic signed [SAMPLE_W-1:0] coef_d  [N];

  logic accept, coef_wr;
  logic mac_clr, mac_en, mac_load;

  assign accept  = (state_q == IDLE) && in_valid;
  assign coef_wr = coef_we && coef_ready;

  // Address decode against each tap index also drops addresses >= N.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign shift_d[gi] = accept ? x_in : shift_q[gi];
      end else begin : g_body
        assign shift_d[gi] = accept ? shift_q[gi-1] : shift_q[gi];
      end
      assign coef_d[gi] = (coef_wr && (coef_addr == ADDR_W'(gi))) ? coef_wdata : coef_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        shift_q[k] <= '0;
        coef_q[k]  <= '0;
      end
    end else begin
      shift_q <= shift_d;
      coef_q  <= coef_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    in_ready   = 1'b0;
    coef_ready = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    mac_load   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready   = 1'b1;
        coef_ready = 1'b1;
        if (in_valid) begin
          state_d = MAC;
          tap_d   = '0;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap_q == LAST_TAP) begin
          mac_load = 1'b1;
          state_d  = OUT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  assign out_valid = (state_q == OUT);

  fir_mac_unit #(
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .load_i   (mac_load),
    .coef_i   (coef_q[tap_q]),
    .sample_i (shift_q[tap_q]),
    .y_o      (y_out),
    .y_sat_o  (y_sat)
  );

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Directed and randomized checks of the TDM FIR sequencer against a
// convolution model of the delay line and coefficient bank.
module tb_fir_tdm_sequencer;

  localparam int N  = 4;
  localparam int SW = 8;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [SW-1:0] x_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 coef_we;
  logic [1:0]           coef_addr;
  logic signed [SW-1:0] coef_wdata;
  logic                 coef_ready;
  logic signed [OW-1:0] y_out;
  logic                 y_sat;
  logic                 out_valid;
  logic                 out_ready;

  int passed = 0;
  int total  = 0;

  int coef_m [N];
  int hist_m [N];

  fir_tdm_sequencer #(.N(N), .SAMPLE_W(SW), .OUT_W(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .x_in       (x_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_ready (coef_ready),
    .y_out      (y_out),
    .y_sat      (y_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      coef_m[k] = 0;
      hist_m[k] = 0;
    end
  endtask

  // FIR output y[n] = sum_k c[k]*x[n-k], clamped to the OW-bit signed range.
  task automatic model_expect(output int y, output int sat);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += coef_m[k] * hist_m[k];
    sat = 0;
    y   = s;
    if (s > 32767) begin
      y = 32767;
      sat = 1;
    end else if (s < -32768) begin
      y = -32768;
      sat = 1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    model_clear();
    check("rst_out_valid", out_valid, 0);
    check("rst_y_out", y_out, 0);
    check("rst_y_sat", y_sat, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_coef_ready", coef_ready, 1);
  endtask

  // Only called while the sequencer is idle, so the write always commits.
  task automatic write_coef(input logic [1:0] addr, input logic signed [SW-1:0] val);
    coef_we    = 1'b1;
    coef_addr  = addr;
    coef_wdata = val;
    tick();
    coef_we = 1'b0;
    coef_m[addr] = val;
  endtask

  task automatic run_sample(input logic signed [SW-1:0] x, input bit busy_we,
                            input bit sim_we, input logic [1:0] sim_addr,
                            input logic signed [SW-1:0] sim_val, input int bp);
    int cnt;
    int ey;
    int es;
    cnt = 0;
    while (!in_ready && cnt < 10) begin
      tick();
      cnt++;
    end
    check("in_ready_before_accept", in_ready, 1);
    x_in     = x;
    in_valid = 1'b1;
    if (sim_we) begin
      coef_we    = 1'b1;
      coef_addr  = sim_addr;
      coef_wdata = sim_val;
    end
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (sim_we) coef_m[sim_addr] = sim_val;
    for (int k = N - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = x;
    model_expect(ey, es);

    check("mac_in_ready", in_ready, 0);
    check("mac_coef_ready", coef_ready, 0);
    cnt = 0;
    if (busy_we) begin
      coef_we    = 1'b1;
      coef_addr  = 2'd0;
      coef_wdata = 8'sd10;
      tick();
      coef_we = 1'b0;
      cnt = 1;
    end
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("latency", cnt, N);
    check("y_out", y_out, ey);
    check("y_sat", y_sat, es);
    $display("sample x=%0d y_out=%0d y_sat=%0d expected=%0d/%0d latency=%0d",
             x, y_out, y_sat, ey, es, cnt + 1);

    if (bp > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x_in      = 8'sd99;
      for (int i = 0; i < bp; i++) begin
        tick();
        check("bp_out_valid", out_valid, 1);
        check("bp_y_stable", y_out, ey);
        check("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [31:0] r;
    logic signed [SW-1:0] xv;
    logic signed [SW-1:0] cv;
    logic signed [SW-1:0] coefs [N];

    rst        = 1'b1;
    x_in       = '0;
    in_valid   = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    out_ready  = 1'b1;
    model_clear();
    do_reset(2);

    coefs[0] = 8'sd2;
    coefs[1] = 8'sd4;
    coefs[2] = 8'sd4;
    coefs[3] = 8'sd2;
    for (int k = 0; k < N; k++) write_coef(2'(k), coefs[k]);
    run_sample(8'sd1, 1'b0, 1'b0, 2'd0, 8'sd0, 0);
    for (int i = 0; i < 4; i++) run_sample(8'sd0, 1'b0, 1'b0, 2'd0, 8'sd0, 0);

    run_sample(8'sd5, 1'b0, 1'b0, 2'd0, 8'sd0, 10);
    run_sample(-8'sd3, 1'b0, 1'b0, 2'd0, 8'sd0, 0);

    for (int k = 0; k < N; k++) write_coef(2'(k), 8'sd127);
    for (int i = 0; i < 4; i++) run_sample(8'sd127, 1'b0, 1'b0, 2'd0, 8'sd0, 0);
    for (int i = 0; i < 4; i++) run_sample(-8'sd128, 1'b0, 1'b0, 2'd0, 8'sd0, 0);

    for (int k = 0; k < N; k++) write_coef(2'(k), coefs[k]);
    run_sample(8'sd1, 1'b1, 1'b0, 2'd0, 8'sd0, 0);
    run_sample(8'sd1, 1'b0, 1'b1, 2'd0, 8'sd10, 0);

    x_in     = 8'sd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_out_valid", out_valid, 0);
    end
    run_sample(8'sd1, 1'b0, 1'b0, 2'd0, 8'sd0, 0);
    for (int k = 0; k < N; k++) write_coef(2'(k), coefs[k]);
    run_sample(8'sd1, 1'b0, 1'b0, 2'd0, 8'sd0, 0);
    for (int i = 0; i < 4; i++) run_sample(8'sd0, 1'b0, 1'b0, 2'd0, 8'sd0, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r  = $urandom;
        cv = r[7:0];
        write_coef(r[9:8], cv);
      end
      r  = $urandom;
      xv = r[7:0];
      cv = r[15:8];
      run_sample(xv, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 r[17:16], cv, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
